// File: rtl/power_reset_sequencer_pkg.sv
// Shared state encodings and default timing for the board power/reset sequencer.
package power_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DOWN  = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_t;

    localparam int DEF_NUM_RAILS    = 2;
    localparam int DEF_RAIL_STAGGER = 4;
    localparam int DEF_RAMP_TIMEOUT = 16;
    localparam int DEF_RST_HOLD     = 8;
    localparam int DEF_GLITCH_FILT  = 3;
    localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/power_reset_sequencer_rail_deglitch.sv
// Per-rail brownout filter: once an enabled rail has been seen good, count
// consecutive low samples and flag a brownout on the GLITCH_FILT-th one.
module power_reset_sequencer_rail_deglitch
    import power_reset_sequencer_pkg::*;
#(
    parameter int GLITCH_FILT = DEF_GLITCH_FILT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ok,
    output logic brownout
);

    localparam int FW = $clog2(GLITCH_FILT + 1);
    localparam logic [FW-1:0] LOW_TC = FW'(GLITCH_FILT - 1);

    logic          seen_good;
    logic [FW-1:0] low_cnt;

    // Good flag and low-sample counter; both forget everything when the rail is off.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            seen_good <= 1'b0;
            low_cnt   <= '0;
        end else if (ok) begin
            seen_good <= 1'b1;
            low_cnt   <= '0;
        end else if (seen_good && (low_cnt != LOW_TC)) begin
            low_cnt <= low_cnt + FW'(1);
        end
    end

    // Asserted during the cycle whose low sample would be the GLITCH_FILT-th in a row.
    assign brownout = en && seen_good && !ok && (low_cnt == LOW_TC);

endmodule

// File: rtl/power_reset_sequencer.sv
// Board power and reset sequencer: staggered rail enable with ramp supervision,
// reset hold, staggered descending shutdown, and sticky brownout/timeout fault.
//
// state  | meaning
// -------+---------------------------------------------------------------
// OFF    | all rails off, sys_rst held; waits for pwr_req
// RAMP   | rail idx enabled, waiting for stagger time and rail_ok[idx]
// HOLD   | all rails good, sys_rst held for RST_HOLD clocks
// RUN    | logic released, pwr_good=1
// DOWN   | rails cleared highest-first, one per RAIL_STAGGER clocks
// FAULT  | all rails off, fault=1 until pwr_req is dropped
module power_reset_sequencer
    import power_reset_sequencer_pkg::*;
#(
    parameter int NUM_RAILS    = DEF_NUM_RAILS,
    parameter int RAIL_STAGGER = DEF_RAIL_STAGGER,
    parameter int RAMP_TIMEOUT = DEF_RAMP_TIMEOUT,
    parameter int RST_HOLD     = DEF_RST_HOLD,
    parameter int GLITCH_FILT  = DEF_GLITCH_FILT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwr_req,
    input  logic [NUM_RAILS-1:0] rail_ok,
    output logic [NUM_RAILS-1:0] vcc_en,
    output logic                 sys_rst,
    output logic                 pwr_good,
    output logic                 fault,
    output logic [2:0]           state
);

    localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);
    localparam logic [CNT_W-1:0] STG_TC   = CNT_W'(RAIL_STAGGER - 1);
    localparam logic [CNT_W-1:0] TO_TC    = CNT_W'(RAMP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(RST_HOLD - 1);

    seq_state_t           state_q, state_n;
    logic [CNT_W-1:0]     timer_q, timer_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [NUM_RAILS-1:0] vcc_en_n;
    logic                 sys_rst_n, pwr_good_n, fault_n;
    logic [NUM_RAILS-1:0] bo_vec, mon_mask;
    logic                 brown;

    for (genvar g = 0; g < NUM_RAILS; g++) begin : g_rail
        power_reset_sequencer_rail_deglitch #(
            .GLITCH_FILT(GLITCH_FILT)
        ) u_rail_deglitch (
            .clk      (clk),
            .rst      (rst),
            .en       (vcc_en[g]),
            .ok       (rail_ok[g]),
            .brownout (bo_vec[g])
        );
    end

    // Rails come up as a thermometer code, so vcc_en >> 1 is exactly the set
    // of rails below idx during RAMP.
    always_comb begin
        mon_mask = '0;
        case (state_q)
            ST_RAMP:         mon_mask = vcc_en >> 1;
            ST_HOLD, ST_RUN: mon_mask = vcc_en;
            default:         mon_mask = '0;
        endcase
        brown = |(bo_vec & mon_mask);
    end

    // State and output registers; reset beats every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            timer_q  <= '0;
            idx_q    <= '0;
            vcc_en   <= '0;
            sys_rst  <= 1'b1;
            pwr_good <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_n;
            timer_q  <= timer_n;
            idx_q    <= idx_n;
            vcc_en   <= vcc_en_n;
            sys_rst  <= sys_rst_n;
            pwr_good <= pwr_good_n;
            fault    <= fault_n;
        end
    end

    // Next-state and next-output logic; fault beats pwr_req drop beats advance.
    always_comb begin
        state_n    = state_q;
        timer_n    = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
        idx_n      = idx_q;
        vcc_en_n   = vcc_en;
        sys_rst_n  = sys_rst;
        pwr_good_n = pwr_good;
        fault_n    = fault;

        case (state_q)
            ST_OFF: begin
                sys_rst_n  = 1'b1;
                pwr_good_n = 1'b0;
                if (pwr_req) begin
                    state_n     = ST_RAMP;
                    timer_n     = '0;
                    idx_n       = '0;
                    vcc_en_n    = '0;
                    vcc_en_n[0] = 1'b1;
                end
            end
            ST_RAMP: begin
                if (brown || ((timer_q >= TO_TC) && !rail_ok[idx_q])) begin
                    state_n = ST_FAULT;
                end else if (!pwr_req) begin
                    state_n = ST_DOWN;
                end else if ((timer_q >= STG_TC) && rail_ok[idx_q]) begin
                    timer_n = '0;
                    if (idx_q == LAST_IDX) begin
                        state_n = ST_HOLD;
                    end else begin
                        idx_n       = idx_q + IDX_W'(1);
                        vcc_en_n    = vcc_en << 1;
                        vcc_en_n[0] = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (brown) begin
                    state_n = ST_FAULT;
                end else if (!pwr_req) begin
                    state_n = ST_DOWN;
                end else if (timer_q >= HOLD_TC) begin
                    state_n    = ST_RUN;
                    sys_rst_n  = 1'b0;
                    pwr_good_n = 1'b1;
                end
            end
            ST_RUN: begin
                if (brown) begin
                    state_n = ST_FAULT;
                end else if (!pwr_req) begin
                    state_n = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (vcc_en == '0) begin
                    state_n = ST_OFF;
                    timer_n = '0;
                end else if (timer_q >= STG_TC) begin
                    vcc_en_n = vcc_en >> 1;
                    timer_n  = '0;
                end
            end
            ST_FAULT: begin
                if (!pwr_req) begin
                    state_n = ST_OFF;
                    fault_n = 1'b0;
                    timer_n = '0;
                end
            end
            default: begin
                state_n = ST_OFF;
            end
        endcase

        // Entry actions shared by every path into DOWN or FAULT.
        if ((state_n == ST_DOWN) && (state_q != ST_DOWN)) begin
            sys_rst_n  = 1'b1;
            pwr_good_n = 1'b0;
            vcc_en_n   = vcc_en >> 1;
            timer_n    = '0;
        end
        if ((state_n == ST_FAULT) && (state_q != ST_FAULT)) begin
            sys_rst_n  = 1'b1;
            pwr_good_n = 1'b0;
            fault_n    = 1'b1;
            vcc_en_n   = '0;
            timer_n    = '0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_power_reset_sequencer.sv
// Bench for power_reset_sequencer: stimulus records drive the inputs for a
// number of edges and push the expected outputs; a negedge monitor pops and checks.
module tb_power_reset_sequencer;

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_RAMP  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DOWN  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    typedef struct {
        logic       rst;
        logic       pwr;
        logic [1:0] ok;
        int         n;
        logic [2:0] st;
        logic [1:0] vcc;
        logic       srst;
        logic       pg;
        logic       flt;
        string      name;
    } vec_t;

    typedef struct {
        int         target;
        logic [7:0] exp;
        string      name;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_req;
    logic [1:0] rail_ok;
    logic [1:0] vcc_en;
    logic       sys_rst;
    logic       pwr_good;
    logic       fault;
    logic [2:0] state;

    int   edges = 0;
    int   total = 0;
    int   bad   = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    power_reset_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .pwr_req  (pwr_req),
        .rail_ok  (rail_ok),
        .vcc_en   (vcc_en),
        .sys_rst  (sys_rst),
        .pwr_good (pwr_good),
        .fault    (fault),
        .state    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    // Scoreboard checker: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].target == edges) begin
            sb_t e;
            logic [7:0] act;
            e   = sb.pop_front();
            act = {state, vcc_en, sys_rst, pwr_good, fault};
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got state=%0d vcc_en=%b sys_rst=%b pwr_good=%b fault=%b, want state=%0d vcc_en=%b sys_rst=%b pwr_good=%b fault=%b",
                         e.name, act[7:5], act[4:3], act[2], act[1], act[0],
                         e.exp[7:5], e.exp[4:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    end

    function automatic vec_t mk(input logic r, input logic p, input logic [1:0] o, input int n,
                                input logic [2:0] st, input logic [1:0] vcc, input logic srst,
                                input logic pg, input logic flt, input string name);
        vec_t v;
        v.rst = r; v.pwr = p; v.ok = o; v.n = n;
        v.st = st; v.vcc = vcc; v.srst = srst; v.pg = pg; v.flt = flt; v.name = name;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        sb_t e;
        @(negedge clk);
        rst     = v.rst;
        pwr_req = v.pwr;
        rail_ok = v.ok;
        e.target = edges + v.n;
        e.exp    = {v.st, v.vcc, v.srst, v.pg, v.flt};
        e.name   = v.name;
        sb.push_back(e);
        repeat (v.n) @(posedge clk);
    endtask

    task automatic step(input logic r, input logic p, input logic [1:0] o, input int n,
                        input logic [2:0] st, input logic [1:0] vcc, input logic srst,
                        input logic pg, input logic flt, input string name);
        run_vec(mk(r, p, o, n, st, vcc, srst, pg, flt, name));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        pwr_req = 1'b0;
        rail_ok = 2'b11;

        //                 rst  pwr  ok     n   state    vcc    srst pg   flt
        tbl.push_back(mk(1'b1,1'b0,2'b11, 2, S_OFF,   2'b00,1'b1,1'b0,1'b0,"reset"));
        // power-up with both rails good
        tbl.push_back(mk(1'b0,1'b1,2'b11, 1, S_RAMP,  2'b01,1'b1,1'b0,1'b0,"t1_edge0"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 3, S_RAMP,  2'b01,1'b1,1'b0,1'b0,"t1_edge3"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 1, S_RAMP,  2'b11,1'b1,1'b0,1'b0,"t1_edge4"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 3, S_RAMP,  2'b11,1'b1,1'b0,1'b0,"t1_edge7"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 1, S_HOLD,  2'b11,1'b1,1'b0,1'b0,"t1_edge8"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 7, S_HOLD,  2'b11,1'b1,1'b0,1'b0,"t1_edge15"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 1, S_RUN,   2'b11,1'b0,1'b1,1'b0,"t1_edge16"));
        // brownout filter on rail 0 in RUN
        tbl.push_back(mk(1'b0,1'b1,2'b10, 2, S_RUN,   2'b11,1'b0,1'b1,1'b0,"t3_low2"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 1, S_RUN,   2'b11,1'b0,1'b1,1'b0,"t3_recover"));
        tbl.push_back(mk(1'b0,1'b1,2'b10, 2, S_RUN,   2'b11,1'b0,1'b1,1'b0,"t3_low2_again"));
        tbl.push_back(mk(1'b0,1'b1,2'b10, 1, S_FAULT, 2'b00,1'b1,1'b0,1'b1,"t3_low3"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 3, S_FAULT, 2'b00,1'b1,1'b0,1'b1,"fault_sticky"));
        tbl.push_back(mk(1'b0,1'b0,2'b11, 1, S_OFF,   2'b00,1'b1,1'b0,1'b0,"fault_clear"));
        // rail 1 never comes good: ramp timeout
        tbl.push_back(mk(1'b0,1'b1,2'b01, 1, S_RAMP,  2'b01,1'b1,1'b0,1'b0,"t2_edge0"));
        tbl.push_back(mk(1'b0,1'b1,2'b01, 4, S_RAMP,  2'b11,1'b1,1'b0,1'b0,"t2_edge4"));
        tbl.push_back(mk(1'b0,1'b1,2'b01,15, S_RAMP,  2'b11,1'b1,1'b0,1'b0,"t2_edge19"));
        tbl.push_back(mk(1'b0,1'b1,2'b01, 1, S_FAULT, 2'b00,1'b1,1'b0,1'b1,"t2_edge20"));
        tbl.push_back(mk(1'b0,1'b0,2'b01, 1, S_OFF,   2'b00,1'b1,1'b0,1'b0,"t2_clear"));
        // orderly shutdown from RUN, re-request ignored in DOWN
        tbl.push_back(mk(1'b0,1'b1,2'b11,17, S_RUN,   2'b11,1'b0,1'b1,1'b0,"t4_run"));
        tbl.push_back(mk(1'b0,1'b0,2'b11, 1, S_DOWN,  2'b01,1'b1,1'b0,1'b0,"t4_drop"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 3, S_DOWN,  2'b01,1'b1,1'b0,1'b0,"t4_reraise_ignored"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 1, S_DOWN,  2'b00,1'b1,1'b0,1'b0,"t4_rail0_off"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 1, S_OFF,   2'b00,1'b1,1'b0,1'b0,"t4_off"));
        tbl.push_back(mk(1'b0,1'b1,2'b11, 1, S_RAMP,  2'b01,1'b1,1'b0,1'b0,"t4_restart"));

        foreach (tbl[i]) run_vec(tbl[i]);

        // reset mid-ramp with both rails on, then a clean restart from zero
        step(1'b0,1'b1,2'b11, 4, S_RAMP,  2'b11,1'b1,1'b0,1'b0,"t6_ramp11");
        step(1'b1,1'b1,2'b11, 1, S_OFF,   2'b00,1'b1,1'b0,1'b0,"t6_rst");
        step(1'b0,1'b0,2'b11, 1, S_OFF,   2'b00,1'b1,1'b0,1'b0,"t6_idle");
        step(1'b0,1'b1,2'b11, 1, S_RAMP,  2'b01,1'b1,1'b0,1'b0,"t6_edge0");
        step(1'b0,1'b1,2'b11, 3, S_RAMP,  2'b01,1'b1,1'b0,1'b0,"t6_edge3");
        step(1'b0,1'b1,2'b11, 1, S_RAMP,  2'b11,1'b1,1'b0,1'b0,"t6_edge4");

        // brownout and pwr_req drop on the same edge in HOLD
        step(1'b0,1'b1,2'b11, 4, S_HOLD,  2'b11,1'b1,1'b0,1'b0,"t5_hold");
        step(1'b0,1'b1,2'b10, 2, S_HOLD,  2'b11,1'b1,1'b0,1'b0,"t5_low2");
        step(1'b0,1'b0,2'b10, 1, S_FAULT, 2'b00,1'b1,1'b0,1'b1,"t5_fault_not_down");
        step(1'b0,1'b0,2'b11, 1, S_OFF,   2'b00,1'b1,1'b0,1'b0,"t5_clear");

        // pwr_req drop while only rail 0 is on
        step(1'b0,1'b1,2'b11, 1, S_RAMP,  2'b01,1'b1,1'b0,1'b0,"ramp_drop_start");
        step(1'b0,1'b0,2'b11, 1, S_DOWN,  2'b00,1'b1,1'b0,1'b0,"ramp_drop_down");
        step(1'b0,1'b0,2'b11, 1, S_OFF,   2'b00,1'b1,1'b0,1'b0,"ramp_drop_off");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got pending=%0d, want pending=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
